// File: rtl/xgmac_pause_ctrl.sv
// Pause-frame request generator for the 10G MAC RX path: watches RX FIFO fill
// level and issues rate-limited XOFF / refresh / XON pause requests.
module xgmac_pause_ctrl #(
  parameter int C_LVL_W   = 12,
  parameter int C_MIN_GAP = 64
) (
  input  logic               clk156,
  input  logic               aresetn,
  input  logic               cfg_enable,
  input  logic [C_LVL_W-1:0] cfg_xoff_thresh,
  input  logic [C_LVL_W-1:0] cfg_xon_thresh,
  input  logic [15:0]        cfg_quanta,
  input  logic [15:0]        cfg_refresh,
  input  logic               link_up,
  input  logic [C_LVL_W-1:0] fifo_level,
  output logic               pause_req,
  output logic [15:0]        pause_val,
  output logic               xoff_active,
  output logic               cfg_err,
  output logic [15:0]        xoff_count,
  output logic [15:0]        xon_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, XOFF = 1'b1} state_e;

  localparam logic [7:0] GAP_LOAD = 8'(C_MIN_GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] tmr_q, tmr_d;
  logic        pause_req_q, pause_req_d;
  logic [15:0] pause_val_q, pause_val_d;
  logic        cfg_err_q, cfg_err_d;
  logic [15:0] xoff_count_q, xoff_count_d;
  logic [15:0] xon_count_q, xon_count_d;

  logic        emit;
  logic [15:0] emit_val;
  logic        tmr_load;
  logic        gap_ok;

  assign gap_ok = (gap_cnt_q == 8'd0);

  // State register
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and emit decision; any emit waits for the gap counter to drain
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_val = 16'd0;
    tmr_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable && link_up && !cfg_err_q && (fifo_level >= cfg_xoff_thresh) && gap_ok) begin
          state_d  = XOFF;
          emit     = 1'b1;
          emit_val = cfg_quanta;
          tmr_load = 1'b1;
        end
      end
      XOFF: begin
        if (!link_up) begin
          // Link loss silently drops XOFF, including a pending deferred XON
          state_d = IDLE;
        end else if (!cfg_enable || cfg_err_q || (fifo_level <= cfg_xon_thresh)) begin
          if (gap_ok) begin
            state_d  = IDLE;
            emit     = 1'b1;
            emit_val = 16'd0;
          end
        end else if ((cfg_refresh != 16'd0) && (tmr_q == 16'd0) && gap_ok) begin
          emit     = 1'b1;
          emit_val = cfg_quanta;
          tmr_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pause_req_d  = emit;
    pause_val_d  = emit ? emit_val : 16'd0;
    cfg_err_d    = (cfg_xon_thresh >= cfg_xoff_thresh);
    gap_cnt_d    = emit ? GAP_LOAD : (gap_ok ? 8'd0 : gap_cnt_q - 8'd1);
    tmr_d        = tmr_load ? cfg_refresh : ((tmr_q != 16'd0) ? tmr_q - 16'd1 : 16'd0);
    xoff_count_d = xoff_count_q;
    xon_count_d  = xon_count_q;
    if (emit && (emit_val != 16'd0) && (xoff_count_q != 16'hFFFF)) xoff_count_d = xoff_count_q + 16'd1;
    if (emit && (emit_val == 16'd0) && (xon_count_q  != 16'hFFFF)) xon_count_d  = xon_count_q + 16'd1;
  end

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      gap_cnt_q    <= 8'd0;
      tmr_q        <= 16'd0;
      pause_req_q  <= 1'b0;
      pause_val_q  <= 16'd0;
      cfg_err_q    <= 1'b0;
      xoff_count_q <= 16'd0;
      xon_count_q  <= 16'd0;
    end else begin
      gap_cnt_q    <= gap_cnt_d;
      tmr_q        <= tmr_d;
      pause_req_q  <= pause_req_d;
      pause_val_q  <= pause_val_d;
      cfg_err_q    <= cfg_err_d;
      xoff_count_q <= xoff_count_d;
      xon_count_q  <= xon_count_d;
    end
  end

  assign pause_req   = pause_req_q;
  assign pause_val   = pause_val_q;
  assign xoff_active = (state_q == XOFF);
  assign cfg_err     = cfg_err_q;
  assign xoff_count  = xoff_count_q;
  assign xon_count   = xon_count_q;

endmodule

// File: tb/tb_xgmac_pause_ctrl.sv
// Directed bench for xgmac_pause_ctrl: XOFF/XON handshake, refresh period,
// minimum gap, link loss, config error, async reset.
module tb_xgmac_pause_ctrl;

  localparam int LW = 12;

  logic          clk156 = 1'b0;
  logic          aresetn;
  logic          cfg_enable;
  logic [LW-1:0] cfg_xoff_thresh, cfg_xon_thresh, fifo_level;
  logic [15:0]   cfg_quanta, cfg_refresh;
  logic          link_up;
  logic          pause_req;
  logic [15:0]   pause_val;
  logic          xoff_active, cfg_err;
  logic [15:0]   xoff_count, xon_count;

  int checks   = 0;
  int failures = 0;

  xgmac_pause_ctrl #(.C_LVL_W(LW), .C_MIN_GAP(64)) dut (
    .clk156(clk156), .aresetn(aresetn), .cfg_enable(cfg_enable),
    .cfg_xoff_thresh(cfg_xoff_thresh), .cfg_xon_thresh(cfg_xon_thresh),
    .cfg_quanta(cfg_quanta), .cfg_refresh(cfg_refresh), .link_up(link_up),
    .fifo_level(fifo_level), .pause_req(pause_req), .pause_val(pause_val),
    .xoff_active(xoff_active), .cfg_err(cfg_err),
    .xoff_count(xoff_count), .xon_count(xon_count)
  );

  always #5 clk156 = ~clk156;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk156);
  endtask

  // Advance until pause_req is seen; returns cycles taken or -1 on timeout
  task automatic wait_pulse(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick(1);
      if (pause_req) begin n = i; break; end
    end
  endtask

  // Count pulses over a window
  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (pause_req) n++;
    end
  endtask

  int n;

  initial begin
    aresetn = 1'b0; cfg_enable = 1'b1; link_up = 1'b1;
    cfg_xoff_thresh = 12'd3000; cfg_xon_thresh = 12'd1000;
    cfg_quanta = 16'h00FF; cfg_refresh = 16'd0; fifo_level = '0;
    tick(3);
    chk("rst_req",   {31'd0, pause_req}, 32'd0);
    chk("rst_val",   {16'd0, pause_val}, 32'd0);
    chk("rst_xoff",  {31'd0, xoff_active}, 32'd0);
    chk("rst_err",   {31'd0, cfg_err}, 32'd0);
    chk("rst_cnt",   {xoff_count, xon_count}, 32'd0);
    aresetn = 1'b1;

    // Basic XOFF then XON
    fifo_level = 12'd1000; tick(1);
    fifo_level = 12'd2000; tick(1);
    fifo_level = 12'd2999; tick(1);
    chk("ramp_nopulse", {31'd0, pause_req}, 32'd0);
    fifo_level = 12'd3000; tick(1);
    chk("xoff_req", {31'd0, pause_req}, 32'd1);
    chk("xoff_val", {16'd0, pause_val}, 32'h00FF);
    chk("xoff_act", {31'd0, xoff_active}, 32'd1);
    tick(1);
    chk("xoff_1cyc", {15'd0, pause_req, pause_val}, 32'd0);
    count_pulses(70, n);
    chk("no_refresh", n, 0);
    fifo_level = 12'd1000; tick(1);
    chk("xon_req", {31'd0, pause_req}, 32'd1);
    chk("xon_val", {16'd0, pause_val}, 32'd0);
    chk("xon_idle", {31'd0, xoff_active}, 32'd0);
    chk("cnt_1_1", {xoff_count, xon_count}, {16'd1, 16'd1});

    // Minimum gap: XON deferred to exactly 64 cycles after XOFF
    fifo_level = 12'd0; tick(70);
    fifo_level = 12'd3000; tick(1);
    chk("gap_xoff", {31'd0, pause_req}, 32'd1);
    fifo_level = 12'd500;
    wait_pulse(100, n);
    chk("gap_dist", n, 64);
    chk("gap_val", {16'd0, pause_val}, 32'd0);
    chk("cnt_2_2", {xoff_count, xon_count}, {16'd2, 16'd2});

    // Refresh every 101 cycles
    tick(70);
    cfg_refresh = 16'd100; fifo_level = 12'd3500; tick(1);
    chk("ref_t0", {15'd0, pause_req, pause_val}, {15'd0, 1'b1, 16'h00FF});
    wait_pulse(200, n);
    chk("ref_t1", n, 101);
    chk("ref_v1", {16'd0, pause_val}, 32'h00FF);
    wait_pulse(200, n);
    chk("ref_t2", n, 101);
    chk("ref_v2", {16'd0, pause_val}, 32'h00FF);
    chk("ref_cnt", {16'd0, xoff_count}, 32'd5);
    cfg_refresh = 16'd0; fifo_level = 12'd500;
    wait_pulse(100, n);
    chk("ref_xon", {15'd0, pause_req, pause_val}, {15'd0, 1'b1, 16'd0});

    // Link loss: silent drop; enable off: XON
    tick(70);
    fifo_level = 12'd3500; tick(1);
    chk("lk_xoff", {31'd0, pause_req}, 32'd1);
    tick(1);
    link_up = 1'b0; tick(1);
    chk("lk_idle", {30'd0, xoff_active, pause_req}, 32'd0);
    count_pulses(70, n);
    chk("lk_silent", n, 0);
    link_up = 1'b1; tick(1);
    chk("lk_reenter", {30'd0, xoff_active, pause_req}, 32'd3);
    tick(70);
    cfg_enable = 1'b0; tick(1);
    chk("en_xon", {14'd0, xoff_active, pause_req, pause_val}, {14'd0, 1'b0, 1'b1, 16'd0});
    chk("cnt_7_4", {xoff_count, xon_count}, {16'd7, 16'd4});

    // Config error blocks XOFF even at full level
    tick(70);
    cfg_enable = 1'b1; fifo_level = 12'd0;
    cfg_xon_thresh = 12'd2000; cfg_xoff_thresh = 12'd2000; tick(2);
    chk("err_set", {31'd0, cfg_err}, 32'd1);
    fifo_level = 12'hFFF;
    count_pulses(20, n);
    chk("err_nopulse", n, 0);
    chk("err_idle", {31'd0, xoff_active}, 32'd0);

    // All-ones level reaches an all-ones threshold
    cfg_xon_thresh = 12'd100; cfg_xoff_thresh = 12'hFFF; tick(2);
    chk("err_clr", {31'd0, cfg_err}, 32'd0);
    chk("full_xoff", {31'd0, pause_req}, 32'd1);
    tick(2);

    // Async reset mid-XOFF
    aresetn = 1'b0; #1;
    chk("ar_out", {13'd0, pause_req, xoff_active, cfg_err, pause_val}, 32'd0);
    chk("ar_cnt", {xoff_count, xon_count}, 32'd0);
    tick(2);
    aresetn = 1'b1; #1;
    chk("ar_rel_cnt", {16'd0, xoff_count}, 32'd0);
    tick(1);
    chk("ar_first", {15'd0, pause_req, pause_val}, {15'd0, 1'b1, 16'h00FF});
    chk("ar_noxon", {16'd0, xon_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/xgmac_pause_ctrl.md
XGMAC_PAUSE_CTRL -- requirements
Module: xgmac_pause_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock clk156, reset aresetn.
REQ-002 Parameter C_LVL_W, default 12, SHALL set the RX FIFO fill-level width.
REQ-003 Parameter C_MIN_GAP, default 64, SHALL set the minimum clk156 cycles between pause_req pulses (range 1..255).
REQ-004 Ports SHALL be:
- clk156  in  1  156.25 MHz MAC core clock
- aresetn  in  1  async active-low reset
- cfg_enable  in  1  flow control enable
- cfg_xoff_thresh  in  C_LVL_W  fill level that triggers XOFF
- cfg_xon_thresh  in  C_LVL_W  fill level that triggers XON
- cfg_quanta  in  16  pause quanta sent with XOFF
- cfg_refresh  in  16  XOFF refresh period in cycles; 0 = no refresh
- link_up  in  1  PCS block lock / link status
- fifo_level  in  C_LVL_W  RX FIFO occupancy
- pause_req  out  1  one-cycle pause request to MAC
- pause_val  out  16  pause quanta, valid while pause_req=1
- xoff_active  out  1  high in XOFF state
- cfg_err  out  1  high while cfg_xon_thresh >= cfg_xoff_thresh
- xoff_count  out  16  saturating count of XOFF pulses
- xon_count  out  16  saturating count of XON pulses

Function
REQ-005 All outputs SHALL be registered; pause_req SHALL assert the cycle after the qualifying input sample (latency 1).
REQ-006 FSM states SHALL be IDLE and XOFF; xoff_active SHALL equal (state==XOFF).
REQ-007 A pulse ("emit v") SHALL drive pause_req=1 and pause_val=v for exactly one cycle, and load gap_cnt with C_MIN_GAP-1.
REQ-008 gap_cnt SHALL decrement to 0 and hold there; no emit SHALL occur while gap_cnt!=0; a transition requiring an emit SHALL be deferred (state held) until gap_cnt==0.
REQ-009 pause_val SHALL be 0 whenever pause_req=0.
REQ-010 IDLE -> XOFF SHALL occur when cfg_enable=1, link_up=1, cfg_err=0 and fifo_level >= cfg_xoff_thresh; it emits cfg_quanta and loads refresh timer with cfg_refresh.
REQ-011 In XOFF, the refresh timer SHALL decrement each cycle while nonzero; when cfg_refresh!=0 and timer==0, the block emits cfg_quanta and reloads the timer (state stays XOFF).
REQ-012 In XOFF, with priority highest first:
- link_up=0: go IDLE immediately, no emit
- cfg_enable=0 or cfg_err=1: emit 0 (XON), go IDLE
- fifo_level <= cfg_xon_thresh: emit 0, go IDLE
- refresh per REQ-011
REQ-013 A deferred XON (REQ-008) SHALL be cancelled to a silent IDLE transition if link_up drops while waiting.
REQ-014 cfg_err SHALL be combinationally derived from the threshold compare and registered; while cfg_err=1 the block SHALL not leave IDLE.
REQ-015 xoff_count / xon_count SHALL increment on each XOFF (pause_val!=0) / XON (pause_val==0) emit and saturate at 16'hFFFF.
REQ-016 Threshold compares SHALL be unsigned, full C_LVL_W width; fifo_level all-ones SHALL be valid.
REQ-017 Config inputs SHALL be sampled every cycle; changing them mid-XOFF SHALL take effect at the next compare/reload, without glitching an in-flight pulse.

Reset
REQ-018 On aresetn=0, asynchronously: state=IDLE, pause_req=0, pause_val=0, xoff_active=0, cfg_err=0, gap_cnt=0, refresh timer=0, both counters=0.
REQ-019 Reset asserted mid-XOFF SHALL emit no XON; after deassertion the block SHALL restart in IDLE and may emit on the first qualifying cycle.

Verification
REQ-020 The bench SHALL cover:
- xoff=3000, xon=1000, quanta=16'h00FF, refresh=0; ramp fifo_level to 3000 -> one pulse pause_val=16'h00FF next cycle, xoff_active=1; drop to 1000 -> pulse pause_val=0, xoff_count=1, xon_count=1.
- refresh=100, level held at 3500 -> XOFF pulses at t0, t0+101, t0+202..., each pause_val=16'h00FF.
- C_MIN_GAP=64; level crosses xoff then xon within 10 cycles -> XON pulse exactly 64 cycles after XOFF pulse.
- In XOFF, link_up=0 -> next cycle IDLE, no pulse; cfg_enable=0 instead -> XON pulse.
- xon=2000, xoff=2000 -> cfg_err=1, no pulse at level 4095.
- aresetn asserted mid-XOFF -> all outputs 0 immediately; xoff_count=0 after release.
